// File: rtl/adc_conv_arbiter.sv
// adc_conv_arbiter: round-robin arbiter and sequencer that shares one SAR ADC
// macro (sample/hold, channel mux, 10-bit DAC, comparator) between NREQ requesters.
// Optional build macro ADC_AVG_EN: each grant runs 4 sample+convert passes and
// returns the truncated average of the four codes.
module adc_conv_arbiter #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned SETTLE = 1
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              enable,
  input  logic [7:0]        sample_cycles,
  input  logic [NREQ-1:0]   req,
  input  logic [3*NREQ-1:0] req_ch,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [9:0]        result,
  output logic              en,
  output logic              dac_rst,
  output logic              sample_n,
  output logic [2:0]        ch_sel_out,
  output logic [9:0]        adc_data,
  input  logic              cmp
);

  localparam int unsigned IW         = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [7:0]  SETTLE_CNT = 8'(SETTLE);

  typedef enum logic [2:0] {StIdle, StArb, StSample, StConv, StDone} state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     rr_q, rr_d;
  logic [IW-1:0]     gidx_q, gidx_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [9:0]        result_q, result_d;
  logic [2:0]        ch_q, ch_d;
  logic [9:0]        code_q, code_d;
  logic [3:0]        bit_q, bit_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              en_q;
`ifdef ADC_AVG_EN
  logic [1:0]        pass_q, pass_d;
  logic [11:0]       acc_q, acc_d;
`endif

  logic              sel_found;
  logic [IW-1:0]     sel_idx;
  int unsigned       idx;
  logic [IW-1:0]     rr_next;
  logic [7:0]        sample_load;
  logic              abort;

  // Round-robin pick: first set req at or after the pointer, wrapping.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    idx       = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(rr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!sel_found && req[IW'(idx)]) begin
        sel_found = 1'b1;
        sel_idx   = IW'(idx);
      end
    end
  end

  assign rr_next     = (gidx_q == IW'(NREQ - 1)) ? '0 : gidx_q + 1'b1;
  assign sample_load = (sample_cycles == 8'd0) ? 8'd0 : sample_cycles - 8'd1;
  // Losing the grantee's request or the block enable kills the conversion.
  assign abort       = !enable || !req[gidx_q];

  // Next-state logic for the sequencer and its datapath registers.
  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    gidx_d   = gidx_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    result_d = result_q;
    ch_d     = ch_q;
    code_d   = code_q;
    bit_d    = bit_q;
    cnt_d    = cnt_q;
`ifdef ADC_AVG_EN
    pass_d   = pass_q;
    acc_d    = acc_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (enable && |req) state_d = StArb;
      end
      StArb: begin
        if (!enable || !sel_found) begin
          state_d = StIdle;
        end else begin
          gidx_d          = sel_idx;
          gnt_d           = '0;
          gnt_d[sel_idx]  = 1'b1;
          ch_d            = req_ch[3*int'(sel_idx) +: 3];
          cnt_d           = sample_load;
          state_d         = StSample;
`ifdef ADC_AVG_EN
          pass_d          = 2'd0;
          acc_d           = 12'd0;
`endif
        end
      end
      StSample: begin
        if (abort) begin
          state_d = StIdle;
          gnt_d   = '0;
          rr_d    = rr_next;
        end else if (cnt_q == 8'd0) begin
          code_d  = 10'h200;
          bit_d   = 4'd9;
          state_d = StConv;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StConv: begin
        if (abort) begin
          state_d = StIdle;
          gnt_d   = '0;
          rr_d    = rr_next;
        end else if (cnt_q == SETTLE_CNT) begin
          cnt_d = 8'd0;
          if (!cmp) code_d[bit_q] = 1'b0;
          if (bit_q != 4'd0) begin
            code_d[bit_q - 4'd1] = 1'b1;
            bit_d                = bit_q - 4'd1;
          end else begin
`ifdef ADC_AVG_EN
            acc_d = acc_q + {2'b00, code_d};
            if (pass_q == 2'd3) begin
              state_d = StDone;
            end else begin
              pass_d  = pass_q + 2'd1;
              cnt_d   = sample_load;
              state_d = StSample;
            end
`else
            state_d = StDone;
`endif
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
        gnt_d   = '0;
        rr_d    = rr_next;
        if (enable) begin
`ifdef ADC_AVG_EN
          result_d = acc_q[11:2];
`else
          result_d = code_q;
`endif
          done_d[gidx_q] = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset is asynchronous and active-high.
  always_ff @(posedge HCLK or posedge HRESETn) begin
    if (HRESETn) begin
      state_q  <= StIdle;
      rr_q     <= '0;
      gidx_q   <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      result_q <= '0;
      ch_q     <= '0;
      code_q   <= '0;
      bit_q    <= '0;
      cnt_q    <= '0;
      en_q     <= 1'b0;
`ifdef ADC_AVG_EN
      pass_q   <= '0;
      acc_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      gidx_q   <= gidx_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      result_q <= result_d;
      ch_q     <= ch_d;
      code_q   <= code_d;
      bit_q    <= bit_d;
      cnt_q    <= cnt_d;
      en_q     <= enable;
`ifdef ADC_AVG_EN
      pass_q   <= pass_d;
      acc_q    <= acc_d;
`endif
    end
  end

  // Analog control pins decode directly from state so reset forces them at once.
  always_comb begin
    sample_n = (state_q != StSample);
    dac_rst  = !((state_q == StSample) || (state_q == StConv));
  end

  assign gnt        = gnt_q;
  assign done       = done_q;
  assign result     = result_q;
  assign en         = en_q;
  assign ch_sel_out = ch_q;
  assign adc_data   = code_q;

endmodule

// File: tb/tb_adc_conv_arbiter.sv
// Directed bench for adc_conv_arbiter with a behavioural comparator: each channel
// has a fixed input code and cmp = (vin[ch_sel_out] >= adc_data).
module tb_adc_conv_arbiter;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        enable;
  logic [7:0]  sample_cycles;
  logic [3:0]  req;
  logic [11:0] req_ch;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic [9:0]  result;
  logic        en;
  logic        dac_rst;
  logic        sample_n;
  logic [2:0]  ch_sel_out;
  logic [9:0]  adc_data;
  logic        cmp;

  logic [9:0]  vin [8];
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 HCLK = ~HCLK;

  assign cmp = (vin[ch_sel_out] >= adc_data);

  adc_conv_arbiter #(
    .NREQ   (4),
    .SETTLE (1)
  ) dut (
    .HCLK          (HCLK),
    .HRESETn       (HRESETn),
    .enable        (enable),
    .sample_cycles (sample_cycles),
    .req           (req),
    .req_ch        (req_ch),
    .gnt           (gnt),
    .done          (done),
    .result        (result),
    .en            (en),
    .dac_rst       (dac_rst),
    .sample_n      (sample_n),
    .ch_sel_out    (ch_sel_out),
    .adc_data      (adc_data),
    .cmp           (cmp)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_gnt"}, 32'(gnt), 32'h0);
    check_eq({tag, "_done"}, 32'(done), 32'h0);
    check_eq({tag, "_result"}, 32'(result), 32'h0);
    check_eq({tag, "_en"}, 32'(en), 32'h0);
    check_eq({tag, "_dac_rst"}, 32'(dac_rst), 32'h1);
    check_eq({tag, "_sample_n"}, 32'(sample_n), 32'h1);
    check_eq({tag, "_ch"}, 32'(ch_sel_out), 32'h0);
    check_eq({tag, "_adc_data"}, 32'(adc_data), 32'h0);
  endtask

  task automatic apply_reset();
    @(negedge HCLK);
    HRESETn = 1'b1;
    req     = '0;
    @(negedge HCLK);
    HRESETn = 1'b0;
  endtask

  // One isolated conversion for requester i; checks latency, sample width,
  // first trial code, latched channel, done target and result.
  task automatic do_single(input int i, input logic [2:0] ch, input logic [9:0] code,
                           input int exp_lat, input int exp_slow, input string tag);
    int         cyc;
    int         slow;
    bit         seen;
    logic [9:0] first;
    logic [2:0] ch_seen;
    cyc = 0; slow = 0; seen = 1'b0; first = '0; ch_seen = '0;
    vin[ch]          = code;
    req_ch[3*i +: 3] = ch;
    enable           = 1'b1;
    req              = '0;
    req[i]           = 1'b1;
    do begin
      @(negedge HCLK);
      cyc++;
      if (!sample_n) slow++;
      if (!seen && sample_n && !dac_rst) begin
        seen    = 1'b1;
        first   = adc_data;
        ch_seen = ch_sel_out;
      end
    end while (done == 4'b0 && cyc < 100);
    check_eq({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    check_eq({tag, "_done"}, 32'(done), 32'(4'b1 << i));
    check_eq({tag, "_result"}, 32'(result), 32'(code));
    check_eq({tag, "_sample_len"}, 32'(slow), 32'(exp_slow));
    check_eq({tag, "_first_trial"}, 32'(first), 32'h200);
    check_eq({tag, "_ch"}, 32'(ch_seen), 32'(ch));
    req[i] = 1'b0;
  endtask

  initial begin
    int cyc;
    int bad_gnt;
    int bad_ch;
    int done1_seen;

    HRESETn       = 1'b1;
    enable        = 1'b0;
    sample_cycles = 8'd4;
    req           = '0;
    req_ch        = '0;
    for (int c = 0; c < 8; c++) vin[c] = '0;
    repeat (2) @(negedge HCLK);
    check_reset_outputs("rst");
    HRESETn = 1'b0;

    // Single request: 27-cycle latency, code 0x2A5 on channel 3.
    do_single(0, 3'd3, 10'h2A5, 27, 4, "single");

    // Round-robin with all four requesting; codes 0x010..0x040 on channels 4..7.
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      req_ch[3*k +: 3] = 3'(k + 4);
      vin[k + 4]       = 10'(16 * (k + 1));
    end
    enable  = 1'b1;
    req     = 4'hF;
    bad_gnt = 0;
    bad_ch  = 0;
    for (int k = 0; k < 5; k++) begin
      cyc = 0;
      do begin
        @(negedge HCLK);
        cyc++;
        if ((gnt & (gnt - 4'd1)) != 4'd0) bad_gnt++;
        for (int j = 0; j < 4; j++) if (gnt[j] && ch_sel_out != 3'(j + 4)) bad_ch++;
      end while (done == 4'b0 && cyc < 60);
      check_eq($sformatf("rr_done%0d", k), 32'(done), 32'(4'b1 << (k % 4)));
      check_eq($sformatf("rr_result%0d", k), 32'(result), 32'(16 * ((k % 4) + 1)));
      if (k == 4) req = '0;
    end
    check_eq("rr_gnt_onehot", 32'(bad_gnt), 32'd0);
    check_eq("rr_ch_sel", 32'(bad_ch), 32'd0);

    // Boundary codes; pointer now at 1 so these are granted immediately.
    do_single(1, 3'd1, 10'h000, 27, 4, "code_min");
    do_single(2, 3'd2, 10'h3FF, 27, 4, "code_max");

    // Abort: requester 1 (code 0) drops during bit 5; requester 2 waits.
    req_ch[5:3] = 3'd1;
    req_ch[8:6] = 3'd3;
    vin[3]      = 10'h2A5;
    req         = 4'b0110;
    done1_seen  = 0;
    cyc         = 0;
    do begin
      @(negedge HCLK);
      cyc++;
      if (done[1]) done1_seen++;
    end while (!(gnt == 4'b0010 && sample_n && !dac_rst) && cyc < 60);
    check_eq("abort_grant1", 32'(gnt), 32'b0010);
    repeat (8) @(negedge HCLK);
    check_eq("abort_bit5_trial", 32'(adc_data), 32'h020);
    req = 4'b0100;
    @(negedge HCLK);
    check_eq("abort_gnt", 32'(gnt), 32'h0);
    check_eq("abort_idle", 32'({sample_n, dac_rst}), 32'b11);
    check_eq("abort_result", 32'(result), 32'h3FF);
    @(negedge HCLK);
    @(negedge HCLK);
    check_eq("abort_next_gnt", 32'(gnt), 32'b0100);
    cyc = 0;
    do begin
      @(negedge HCLK);
      cyc++;
      if (done[1]) done1_seen++;
    end while (done == 4'b0 && cyc < 60);
    check_eq("abort_done2", 32'(done), 32'b0100);
    check_eq("abort_result2", 32'(result), 32'h2A5);
    check_eq("abort_no_done1", 32'(done1_seen), 32'd0);
    req = '0;

    // Enable dropped during SAMPLE, then a clean restart.
    req_ch[2:0] = 3'd3;
    req         = 4'b0001;
    cyc         = 0;
    do begin
      @(negedge HCLK);
      cyc++;
    end while (sample_n && cyc < 50);
    check_eq("en_in_sample", 32'(sample_n), 32'h0);
    enable = 1'b0;
    @(negedge HCLK);
    check_eq("en_off_en", 32'(en), 32'h0);
    check_eq("en_off_sample_n", 32'(sample_n), 32'h1);
    check_eq("en_off_dac_rst", 32'(dac_rst), 32'h1);
    check_eq("en_off_gnt", 32'(gnt), 32'h0);
    check_eq("en_off_done", 32'(done), 32'h0);
    do_single(0, 3'd3, 10'h2A5, 27, 4, "reenable");

    // Zero sample length is treated as one cycle.
    sample_cycles = 8'd0;
    do_single(3, 3'd0, 10'h155, 24, 1, "sample0");

    // Asynchronous reset in the middle of CONV.
    sample_cycles = 8'd4;
    req_ch[2:0]   = 3'd3;
    req           = 4'b0001;
    cyc           = 0;
    do begin
      @(negedge HCLK);
      cyc++;
    end while (!(sample_n && !dac_rst) && cyc < 50);
    repeat (3) @(negedge HCLK);
    HRESETn = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(negedge HCLK);
    HRESETn = 1'b0;
    req     = '0;
    @(negedge HCLK);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/adc_conv_arbiter.md
Name: adc_conv_arbiter

Overview:
- Shares one SAR ADC analog macro (sample/hold, 3-bit channel mux, 10-bit DAC, comparator) between NREQ independent requesters.
- Each requester asks for a conversion on a channel of its choice.
- Round-robin arbitration picks one request; the block then sequences sample, 10-step successive approximation and result return.
- Sits between on-chip requesters (bus wrappers, timers, DMA front-ends) and the analog macro pins.

Parameters:
- NREQ, 4, number of requesters (2..8).
- SETTLE, 1, extra HCLK cycles the DAC/comparator settle per bit before cmp is latched (0..15).

Ports:
- HCLK  input  1  clock.
- HRESETn  input  1  reset, asynchronous, active-high.
- enable  input  1  block enable; drives analog en.
- sample_cycles  input  8  sample phase length in HCLK cycles; 0 treated as 1.
- req  input  NREQ  level request per requester.
- req_ch  input  3*NREQ  channel per requester; bits [3i+2:3i] belong to requester i.
- gnt  output  NREQ  one-hot, active requester; high from ARB exit until DONE.
- done  output  NREQ  one-cycle pulse to the requester whose conversion finished.
- result  output  10  last completed conversion; held until next completion.
- en  output  1  analog enable, equal to registered enable.
- dac_rst  output  1  DAC reset, high when not converting.
- sample_n  output  1  low during sample phase, high (hold) otherwise.
- ch_sel_out  output  3  channel mux select, latched at grant.
- adc_data  output  10  DAC trial code.
- cmp  input  1  comparator; 1 means VIN >= DAC code.

Behaviour:
- Reset values: gnt=0, done=0, result=0, en=0, dac_rst=1, sample_n=1, ch_sel_out=0, adc_data=0; FSM in IDLE; RR pointer at 0.
- States: IDLE, ARB, SAMPLE, CONV, DONE.
- IDLE
  - dac_rst=1.
  - Go to ARB when enable=1 and |req.
- ARB (1 cycle)
  - Select the first set req bit at or after the RR pointer, wrapping.
  - Latch its req_ch into ch_sel_out; assert gnt one-hot; load sample counter.
  - Go to SAMPLE.
- SAMPLE
  - sample_n=0, dac_rst=0 for max(sample_cycles,1) cycles.
  - Then sample_n=1, bit index=9, adc_data=10'h200, go to CONV.
- CONV
  - Per bit: hold adc_data for SETTLE+1 cycles.
  - On the last cycle latch cmp: 1 keeps the trial bit, 0 clears it.
  - Then set the next lower bit as trial.
  - After bit 0, go to DONE with the final code.
- DONE (1 cycle)
  - result <= final code; done[i]=1 for the granted i; gnt cleared.
  - RR pointer <= i+1 mod NREQ.
  - Return to IDLE; adc_data holds the code until the next SAMPLE.
- Latency from req sampled in IDLE to done pulse: 1 (IDLE->ARB) + 1 (ARB) + S + 10*(SETTLE+1) + 1 (DONE) cycles. With S=4, SETTLE=1: 27 cycles.
- Requester drops req mid-conversion: abort at the next edge. Go to IDLE, no done, result unchanged, gnt cleared, RR pointer still advances past i.
- enable falls in any state: abort at the next edge exactly as above; en=0.
- req_ch changes after ARB: ignored until the next grant.
- Multiple req in the same cycle: only one is granted. Others wait and are guaranteed service within NREQ conversions.
- A new req from the just-served requester in the DONE cycle is not eligible until the next ARB; RR order gives others priority.
- Reset mid-conversion: all outputs return to reset values immediately (asynchronous).

Optional Feature:
- Macro: ADC_AVG_EN.
- Defined:
  - Each grant performs 4 back-to-back SAMPLE+CONV passes on the same channel.
  - Passes are accumulated into a 12-bit sum; result = sum[11:2] (truncating).
  - done pulses once after the 4th pass; latency = 2 + 4*(S + 10*(SETTLE+1)) + 1.
  - An abort during any pass discards the accumulator.
- Undefined: single conversion per grant; no accumulator logic.

Test Plan:
- Single request: enable=1, sample_cycles=4, req[0]=1, req_ch[2:0]=3; comparator model cmp=(0x2A5>=adc_data) -> ch_sel_out=3, sample_n low 4 cycles, done[0] pulses 27 cycles after req, result=0x2A5.
- Round-robin: req=4'b1111 held, models return 0x010,0x020,0x030,0x040 per channel -> done order 0,1,2,3,0; each result matches its channel; gnt always one-hot.
- Boundary codes: model codes 0x000 and 0x3FF -> result=0x000 and 0x3FF; adc_data trial sequence starts at 0x200.
- Abort: drop req[1] during CONV bit 5 -> FSM in IDLE next cycle, no done[1], result unchanged, the next pending req[2] is granted.
- enable low mid-SAMPLE -> en=0, sample_n=1, dac_rst=1 next cycle; re-enable restarts cleanly.
- sample_cycles=0 -> sample_n low exactly 1 cycle; HRESETn=1 mid-conversion -> all outputs at reset values immediately.
